// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution output path.
package conv_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 18;
    localparam int unsigned DATA_W_DEFAULT = 16;

    localparam logic [1:0] WE_ALL  = 2'b11;
    localparam logic [1:0] WE_NONE = 2'b00;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } wr_state_t;

endpackage

// File: rtl/raster_counter.sv
// Row/col raster counter with a linear address that tracks row*max_col+col by increments only.
module raster_counter
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [ADDR_W-1:0] max_row,
    input  logic [ADDR_W-1:0] max_col,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] max_row_q, max_row_d;
    logic [ADDR_W-1:0] max_col_q, max_col_d;
    logic              col_wrap;

    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        addr_d    = addr_q;
        max_row_d = max_row_q;
        max_col_d = max_col_q;
        col_wrap  = (col_q == max_col_q - ADDR_W'(1));
        last      = col_wrap && (row_q == max_row_q - ADDR_W'(1));

        if (clear) begin
            row_d     = '0;
            col_d     = '0;
            addr_d    = '0;
            max_row_d = max_row;
            max_col_d = max_col;
        end else if (advance) begin
            // Address wraps modulo 2^ADDR_W when dimensions are out of range.
            addr_d = addr_q + ADDR_W'(1);
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + ADDR_W'(1);
            end else begin
                col_d = col_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            max_row_q <= '0;
            max_col_q <= '0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            addr_q    <= addr_d;
            max_row_q <= max_row_d;
            max_col_q <= max_col_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/output_bram_writer.sv
// Writes a feature map of convolution results into BRAM in raster order, one cycle after each valid.
// Optional OUTPUT_RELU_EN: negative results (sign bit set, including -0) are written as zero.
module output_bram_writer
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] max_row,
    input  logic [ADDR_W-1:0] max_col,
    input  logic [DATA_W-1:0] result_data,
    input  logic              result_valid,
    output logic [ADDR_W-1:0] Output_write_addr,
    output logic [DATA_W-1:0] Output_write_data,
    output logic [1:0]        Output_BRAM_we,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    wr_state_t         state_q, state_d;
    logic              start_acc;
    logic              accept;
    logic              last;
    logic [ADDR_W-1:0] cnt_addr;
    logic [DATA_W-1:0] wr_data;

    assign start_acc = start && (state_q == StIdle);
    assign accept    = result_valid && (state_q == StRun);

    raster_counter #(
        .ADDR_W (ADDR_W)
    ) u_raster_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_acc),
        .advance (accept),
        .max_row (max_row),
        .max_col (max_col),
        .addr    (cnt_addr),
        .last    (last)
    );

`ifdef OUTPUT_RELU_EN
    assign wr_data = result_data[DATA_W-1] ? '0 : result_data;
`else
    assign wr_data = result_data;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Empty map still runs through FLUSH so the caller always sees done.
                    state_d = ((max_row != '0) && (max_col != '0)) ? StRun : StFlush;
                end
            end
            StRun: begin
                if (accept && last) state_d = StFlush;
            end
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            Output_write_addr <= '0;
            Output_write_data <= '0;
            Output_BRAM_we    <= WE_NONE;
            overflow          <= 1'b0;
        end else begin
            state_q        <= state_d;
            Output_BRAM_we <= accept ? WE_ALL : WE_NONE;
            if (accept) begin
                Output_write_addr <= cnt_addr;
                Output_write_data <= wr_data;
            end
            // A dropped result is reported even if a start arrives in the same cycle.
            if (result_valid && (state_q != StRun)) begin
                overflow <= 1'b1;
            end else if (start_acc) begin
                overflow <= 1'b0;
            end
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StFlush);

endmodule

// File: tb/tb_output_bram_writer.sv
// Self-checking bench for output_bram_writer: directed vector table plus multi-cycle pass sequences.
module tb_output_bram_writer;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] max_row;
    logic [ADDR_W-1:0] max_col;
    logic [DATA_W-1:0] result_data;
    logic              result_valid;
    logic [ADDR_W-1:0] Output_write_addr;
    logic [DATA_W-1:0] Output_write_data;
    logic [1:0]        Output_BRAM_we;
    logic              busy;
    logic              done;
    logic              overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    output_bram_writer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .max_row           (max_row),
        .max_col           (max_col),
        .result_data       (result_data),
        .result_valid      (result_valid),
        .Output_write_addr (Output_write_addr),
        .Output_write_data (Output_write_data),
        .Output_BRAM_we    (Output_BRAM_we),
        .busy              (busy),
        .done              (done),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              start;
        logic [ADDR_W-1:0] mr;
        logic [ADDR_W-1:0] mc;
        logic              v;
        logic [DATA_W-1:0] d;
        logic [1:0]        we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;
        logic              done;
        logic              ovf;
    } vec_t;

    vec_t vecs[13];

`ifdef OUTPUT_RELU_EN
    localparam logic [DATA_W-1:0] NEG_OUT = 16'h0000;
`else
    localparam logic [DATA_W-1:0] NEG_OUT = 16'hBC00;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, then advance to 1 ns past the next edge.
    task automatic cyc(input logic r, input logic s, input logic [ADDR_W-1:0] mr,
                       input logic [ADDR_W-1:0] mc, input logic v, input logic [DATA_W-1:0] d);
        rst          = r;
        start        = s;
        max_row      = mr;
        max_col      = mc;
        result_valid = v;
        result_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [1:0] we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic b, input logic dn,
                           input logic ovf);
        chk({name, ".we"}, 32'(Output_BRAM_we), 32'(we));
        if (we != 2'b00) begin
            chk({name, ".addr"}, 32'(Output_write_addr), 32'(addr));
            chk({name, ".data"}, 32'(Output_write_data), 32'(data));
        end
        chk({name, ".busy"}, 32'(busy), 32'(b));
        chk({name, ".done"}, 32'(done), 32'(dn));
        chk({name, ".ovf"}, 32'(overflow), 32'(ovf));
    endtask

    initial begin
        int n_done;

        // rst start mr mc v d | we addr data busy done ovf
        vecs[0]  = '{0, 0, 0, 0, 1, 16'h4000, 2'b00, 0, 0,       0, 0, 1};
        vecs[1]  = '{0, 0, 0, 0, 0, 16'h0000, 2'b00, 0, 0,       0, 0, 1};
        vecs[2]  = '{0, 1, 2, 0, 0, 16'h0000, 2'b00, 0, 0,       1, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 16'h0000, 2'b00, 0, 0,       0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 16'h0000, 2'b00, 0, 0,       0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 1, 16'h1234, 2'b00, 0, 0,       0, 0, 1};
        vecs[6]  = '{0, 1, 1, 1, 0, 16'h0000, 2'b00, 0, 0,       1, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 1, 16'hBC00, 2'b11, 0, NEG_OUT, 1, 1, 0};
        vecs[8]  = '{0, 0, 0, 0, 1, 16'h5555, 2'b00, 0, 0,       0, 0, 1};
        vecs[9]  = '{0, 1, 1, 2, 0, 16'h0000, 2'b00, 0, 0,       1, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 1, 16'hBC00, 2'b11, 0, NEG_OUT, 1, 0, 0};
        vecs[11] = '{0, 1, 7, 7, 1, 16'h3C00, 2'b11, 1, 16'h3C00, 1, 1, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 16'h0000, 2'b00, 0, 0,       0, 0, 0};

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 5, 1, 16'hFFFF);
        chk("reset.addr", 32'(Output_write_addr), 32'h0);
        chk("reset.data", 32'(Output_write_data), 32'h0);
        chk_all("reset", 2'b00, 0, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].rst, vecs[i].start, vecs[i].mr, vecs[i].mc, vecs[i].v, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                    vecs[i].busy, vecs[i].done, vecs[i].ovf);
        end

        // 5x5 pass, 25 back-to-back results.
        cyc(0, 1, 5, 5, 0, 0);
        chk_all("p5.start", 2'b00, 0, 0, 1, 0, 0);
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            cyc(0, 0, 0, 0, 1, 16'h3C00 + 16'(i));
            chk_all($sformatf("p5.w%0d", i), 2'b11, 18'(i), 16'h3C00 + 16'(i), 1,
                    (i == 24), 0);
            if (done) n_done++;
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk_all("p5.after", 2'b00, 0, 0, 0, 0, 0);
        chk("p5.ndone", 32'(n_done), 32'd1);

        // 3x4 pass, results on alternate cycles.
        cyc(0, 1, 3, 4, 0, 0);
        chk_all("p34.start", 2'b00, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, 1, 16'h1000 + 16'(i));
            chk_all($sformatf("p34.w%0d", i), 2'b11, 18'(i), 16'h1000 + 16'(i), 1,
                    (i == 11), 0);
            cyc(0, 0, 0, 0, 0, 0);
            chk_all($sformatf("p34.gap%0d", i), 2'b00, 0, 0, (i != 11), 0, 0);
        end

        // Reset mid-pass, colliding with start and a valid result.
        cyc(0, 1, 5, 5, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 0, 1, 16'h2000 + 16'(i));
            chk($sformatf("rst.w%0d", i), 32'(Output_write_addr), 32'(i));
        end
        cyc(1, 1, 5, 5, 1, 16'h7777);
        chk("rst.addr", 32'(Output_write_addr), 32'h0);
        chk_all("rst.hit", 2'b00, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_all("rst.idle", 2'b00, 0, 0, 0, 0, 0);
        cyc(0, 1, 2, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 16'h0100 + 16'(i));
            chk_all($sformatf("p22.w%0d", i), 2'b11, 18'(i), 16'h0100 + 16'(i), 1,
                    (i == 3), 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk_all("p22.after", 2'b00, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
